// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int CODE_W = 4;
   localparam int DIGITS = 8;

   typedef enum logic [1:0] {
      SCAN = 2'd0,
      PDEB = 2'd1,
      HELD = 2'd2,
      RDEB = 2'd3
   } state_t;

   // Index of the lowest active-low column; ties resolve toward column 0.
   function automatic logic [1:0] lowest_zero(input logic [COLS-1:0] col);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (!col[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key handshake and digit-history bus between the scanner and its consumer.
interface keypad_scanner_if;

   logic                                             key_valid;
   logic [keypad_pkg::CODE_W-1:0]                    key_code;
   logic [keypad_pkg::DIGITS*keypad_pkg::CODE_W-1:0] data_out;
   logic                                             overrun;
   logic                                             key_ack;
   logic                                             clr;

   modport master (
      output key_valid, key_code, data_out, overrun,
      input  key_ack, clr
   );

   modport slave (
      input  key_valid, key_code, data_out, overrun,
      output key_ack, clr
   );

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Parameterised two-flop synchronizer for asynchronous level inputs.
module sync2 #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] meta_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_reg <= RST_VAL;
         dout     <= RST_VAL;
      end else begin
         meta_reg <= din;
         dout     <= meta_reg;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and key history.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 8
`ifdef KEYPAD_REPEAT_EN
  ,parameter int REPEAT_DLY   = 64
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COLS-1:0]    col_n,
   output logic [ROWS-1:0]    row_n,
   keypad_scanner_if.master   kif
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEYPAD_REPEAT_EN
   localparam int RP_W  = $clog2(REPEAT_DLY + 1);
`endif

   logic [COLS-1:0]   col_s;
   logic [DIV_W-1:0]  divcnt;
   logic              sample;
   state_t            state;
   logic [1:0]        row_reg;
   logic [1:0]        col_reg;
   logic [DB_W-1:0]   dbcnt;
   logic              emit_reg;
   logic [CODE_W-1:0] emit_code_reg;
   logic              any_low;
   logic              col_hit;
   logic [1:0]        col_sel;
`ifdef KEYPAD_REPEAT_EN
   logic [RP_W-1:0]   rptcnt;
`endif

   sync2 #(.W(COLS), .RST_VAL('1)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (col_n),
      .dout (col_s)
   );

   assign sample  = (divcnt == DIV_W'(SCAN_DIV - 1));
   assign any_low = ~&col_s;
   assign col_sel = lowest_zero(col_s);
   assign col_hit = ~col_s[col_reg];

   // Scan divider, row drive and debounce FSM; decisions only at sample points.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         divcnt        <= '0;
         state         <= SCAN;
         row_reg       <= 2'd0;
         row_n         <= 4'b1110;
         col_reg       <= 2'd0;
         dbcnt         <= '0;
         emit_reg      <= 1'b0;
         emit_code_reg <= '0;
`ifdef KEYPAD_REPEAT_EN
         rptcnt        <= '0;
`endif
      end else begin
         emit_reg <= 1'b0;
         if (!sample) begin
            divcnt <= divcnt + DIV_W'(1);
         end else begin
            divcnt <= '0;
            case (state)
               SCAN: begin
                  if (any_low) begin
                     col_reg <= col_sel;
                     dbcnt   <= DB_W'(1);
                     if (DEBOUNCE_CNT == 1) begin
                        emit_reg      <= 1'b1;
                        emit_code_reg <= {row_reg, col_sel};
                        state         <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        rptcnt        <= '0;
`endif
                     end else begin
                        state <= PDEB;
                     end
                  end else begin
                     row_reg <= row_reg + 2'd1;
                     row_n   <= {row_n[ROWS-2:0], row_n[ROWS-1]};
                  end
               end
               PDEB: begin
                  if (col_hit) begin
                     if (dbcnt + DB_W'(1) == DB_W'(DEBOUNCE_CNT)) begin
                        emit_reg      <= 1'b1;
                        emit_code_reg <= {row_reg, col_reg};
                        state         <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        rptcnt        <= '0;
`endif
                     end else begin
                        dbcnt <= dbcnt + DB_W'(1);
                     end
                  end else begin
                     // A bounce back to idle resumes scanning immediately.
                     state   <= SCAN;
                     row_reg <= row_reg + 2'd1;
                     row_n   <= {row_n[ROWS-2:0], row_n[ROWS-1]};
                  end
               end
               HELD: begin
                  if (!col_hit) begin
                     dbcnt <= DB_W'(1);
                     state <= (DEBOUNCE_CNT == 1) ? SCAN : RDEB;
                  end
`ifdef KEYPAD_REPEAT_EN
                  else if (rptcnt + RP_W'(1) == RP_W'(REPEAT_DLY)) begin
                     rptcnt        <= '0;
                     emit_reg      <= 1'b1;
                     emit_code_reg <= {row_reg, col_reg};
                  end else begin
                     rptcnt <= rptcnt + RP_W'(1);
                  end
`endif
               end
               RDEB: begin
                  if (!col_hit) begin
                     if (dbcnt + DB_W'(1) == DB_W'(DEBOUNCE_CNT)) begin
                        state <= SCAN;
                     end else begin
                        dbcnt <= dbcnt + DB_W'(1);
                     end
                  end else begin
                     state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                     rptcnt <= '0;
`endif
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   // Consumer-facing handshake; clr discards any emit landing in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kif.key_valid <= 1'b0;
         kif.key_code  <= '0;
         kif.data_out  <= '0;
         kif.overrun   <= 1'b0;
      end else if (kif.clr) begin
         kif.key_valid <= 1'b0;
         kif.data_out  <= '0;
         kif.overrun   <= 1'b0;
      end else if (emit_reg) begin
         kif.data_out  <= {kif.data_out[DIGITS*CODE_W-CODE_W-1:0], emit_code_reg};
         kif.key_valid <= 1'b1;
         if (kif.key_valid && !kif.key_ack) begin
            kif.overrun <= 1'b1;
         end else begin
            kif.key_code <= emit_code_reg;
         end
      end else if (kif.key_valid && kif.key_ack) begin
         kif.key_valid <= 1'b0;
      end
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display path: the display drives digit selects and segment lines out, this block drives keypad rows out and reads columns back.
- Scans a 4x4 active-low key matrix and debounces press and release.
- Emits one key code per press on a valid/ack handshake.
- Keeps a 32-bit shift register of the last 8 hex digits entered; it can feed the display or a CPU-visible register.

Parameters:
- SCAN_DIV, 1000: clk cycles each row stays driven; minimum 4.
- DEBOUNCE_CNT, 8: consecutive stable samples needed to accept a press or a release; minimum 1.
- REPEAT_DLY, 64: samples a key must be held before each auto-repeat (only with KEYPAD_REPEAT_EN).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- col_n, input, 4: keypad columns, pulled up, low = key closed; asynchronous to clk.
- key_ack, input, 1: consumer accepts key_code while key_valid=1.
- clr, input, 1: synchronous clear of data_out, key_valid and overrun.
- row_n, output, 4: one-cold row drive.
- key_valid, output, 1: key_code holds an unacknowledged key.
- key_code, output, 4: row*4+col of the accepted key.
- data_out, output, 32: hex digit history; newest digit in [3:0].
- overrun, output, 1: sticky; a key arrived while key_valid=1.

Behaviour:
- Reset values (rst=0): row_n=4'b1110, key_valid=0, key_code=0, data_out=0, overrun=0, FSM=SCAN, all counters 0.
- col_n passes through a 2-FF synchronizer before use.
- A divider counts 0..SCAN_DIV-1. The sample point is divcnt==SCAN_DIV-1. All FSM decisions happen only at sample points.
- Row index r advances (0→1→2→3→0, row_n rotates left) at sample points only in state SCAN with no key detected. In every other state the row is frozen.
- Column selection: c = lowest index with sync col_n[c]==0.
- FSM states and transitions:
  - SCAN: any column low → latch r,c; dbcnt=1; go to PDEB, or straight to emit if DEBOUNCE_CNT==1.
  - PDEB (press debounce): same column still low → dbcnt++. When dbcnt reaches DEBOUNCE_CNT → emit, go to HELD. Latched column high → SCAN; the row advances at that sample.
  - HELD: latched column high → RDEB with dbcnt=1. Otherwise stay.
  - RDEB (release debounce): column high → dbcnt++. When dbcnt reaches DEBOUNCE_CNT → SCAN. Column low again → HELD.
- Emit (single clk cycle, registered):
  - key_valid=1.
  - key_code={r[1:0],c[1:0]} unless key_valid was already 1 and not being acked.
  - data_out={data_out[27:0],code}.
  - Total latency from a stable press at a sample point to key_valid high = DEBOUNCE_CNT samples + 1 clk.
- Handshake:
  - key_valid and key_code hold until a clk edge with key_ack=1, after which key_valid=0.
  - key_ack while key_valid=0 is ignored.
- Boundary conditions:
  - Emit with key_valid=1 and key_ack=0: overrun set; key_code keeps the old value; data_out still shifts.
  - Emit and key_ack in the same cycle: key_valid stays 1, key_code takes the new value, no overrun.
  - clr=1 has priority over everything: data_out=0, key_valid=0, overrun=0, and any emit in that cycle is discarded. FSM and scan continue.
  - Multiple keys pressed in one row: the lowest column wins. Keys in other rows are invisible while the row is frozen.
  - data_out wraps naturally; the oldest digit drops out of [31:28].
  - rst asserted mid-debounce: immediate return to reset values. No emit after rst deasserts unless a full debounce completes.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter increments per sample. When it reaches REPEAT_DLY → emit the same key again (same handshake and overrun rules) and reset the counter. The counter is cleared on entering HELD.
- Undefined: exactly one emit per press; REPEAT_DLY is unused and no repeat logic is built.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding: SCAN, PDEB, HELD, RDEB.
  - ROWS=4, COLS=4, CODE_W=4, DIGITS=8 constants.
- One natural sub-module, sync2, a parameterised 2-FF synchronizer used on col_n. Everything else stays in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3 unless stated):
- Reset: rst low, then release → row_n=1110, data_out=0, key_valid=0. row_n rotates 1101, 1011, 0111, 1110 every 4 clks with col_n=1111.
- Press row1/col2 stably (col_n=1011 while row_n=1101) → key_valid rises 3 samples +1 clk after detection, key_code=6, data_out=0x00000006. Release → no second emit.
- Bounce: col low 1 sample, high 1 sample, then stable → no emit from the bounce; exactly one emit after 3 stable samples.
- Nine keys 1..9 with an ack each → data_out=0x23456789, overrun=0. Press again without ack → overrun=1, key_code unchanged, data_out shifted.
- Emit coincident with key_ack → key_valid stays 1, new code presented, overrun=0. clr coincident with emit → data_out=0, key_valid=0.
- KEYPAD_REPEAT_EN defined, REPEAT_DLY=5, key held with immediate acks → repeat emits every 5 samples, identical key_code.
